// File: rtl/map_scan_reader_if.sv
// Bundle between the map scan reader, the map RAM controller and the tile drawer.
// Latency: none, wires only.
// Backpressure: plot_valid/plot_ready handshake toward the drawing stage.
interface map_scan_reader_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic       map_readwrite;
  logic [2:0] map_data_in;
  logic [4:0] plot_x;
  logic [4:0] plot_y;
  logic [2:0] plot_type;
  logic       plot_valid;
  logic       plot_ready;

  // The scan reader side
  modport master (
    input  start, map_data_in, plot_ready,
    output busy, done, map_x, map_y, map_readwrite,
           plot_x, plot_y, plot_type, plot_valid
  );

  // The game FSM / RAM controller / drawing stage side
  modport slave (
    output start, map_data_in, plot_ready,
    input  busy, done, map_x, map_y, map_readwrite,
           plot_x, plot_y, plot_type, plot_valid
  );
endinterface

// File: rtl/map_scan_reader.sv
// Walks every map tile in raster order, reads its code and presents it to the drawer.
// Latency: READ_LATENCY+1 cycles per tile with plot_ready high (READ_LATENCY if skipped).
// Backpressure: plot_ready low holds PLOT; x/y and the RAM address stay frozen.
module map_scan_reader #(
  parameter int MAP_WIDTH    = 20,
  parameter int MAP_HEIGHT   = 20,
  parameter int READ_LATENCY = 2,
  parameter int SKIP_EMPTY   = 0
) (
  input  logic                clock_50,
  input  logic                reset_n,
  map_scan_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, PLOT, DONE} state_t;

  localparam logic [4:0] X_LAST   = 5'(MAP_WIDTH - 1);
  localparam logic [4:0] Y_LAST   = 5'(MAP_HEIGHT - 1);
  // READ_LATENCY counts the map_x/map_y output register edge as the first
  // edge, so the code is sampled on the edge where cnt reaches LATENCY-1.
  localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

  state_t     state, state_n;
  logic [4:0] x, y, x_n, y_n;
  logic [1:0] cnt, cnt_n;
  logic [4:0] px, py, px_n, py_n;
  logic [2:0] pt, pt_n;
  logic       busy_q, done_q, pv_q;
  logic       advance;
  logic       last_tile;

  // Next-state, tile walk and capture logic
  always_comb begin
    state_n   = state;
    x_n       = x;
    y_n       = y;
    cnt_n     = cnt;
    px_n      = px;
    py_n      = py;
    pt_n      = pt;
    advance   = 1'b0;
    last_tile = (x == X_LAST) && (y == Y_LAST);

    case (state)
      IDLE: begin
        if (bus.start) begin
          x_n     = '0;
          y_n     = '0;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt + 2'd1;
        if (cnt == CNT_LAST) begin
          pt_n = bus.map_data_in;
          px_n = x;
          py_n = y;
          if ((SKIP_EMPTY != 0) && (bus.map_data_in == 3'd0)) begin
            advance = 1'b1;
          end else begin
            state_n = PLOT;
          end
        end
      end
      PLOT: begin
        if (bus.plot_ready) begin
          advance = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // The last tile leaves x/y parked at the map corner rather than wrapping.
    if (advance) begin
      if (last_tile) begin
        state_n = DONE;
      end else begin
        cnt_n   = '0;
        state_n = WAIT;
        if (x == X_LAST) begin
          x_n = '0;
          y_n = y + 5'd1;
        end else begin
          x_n = x + 5'd1;
        end
      end
    end
  end

  // State, walk position and registered outputs
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      cnt    <= '0;
      px     <= '0;
      py     <= '0;
      pt     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pv_q   <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      cnt    <= cnt_n;
      px     <= px_n;
      py     <= py_n;
      pt     <= pt_n;
      busy_q <= (state_n == WAIT) || (state_n == PLOT);
      done_q <= (state_n == DONE);
      pv_q   <= (state_n == PLOT);
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.map_x         = x;
  assign bus.map_y         = y;
  assign bus.map_readwrite = 1'b0;
  assign bus.plot_x        = px;
  assign bus.plot_y        = py;
  assign bus.plot_type     = pt;
  assign bus.plot_valid    = pv_q;

endmodule

// File: tb/tb_map_scan_reader.sv
// Bench for map_scan_reader: three instances (plain, skip-empty, latency 3) each
// with a model map RAM; expected tiles are queued at start and popped per handshake.
module tb_map_scan_reader;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       start_v = '0;
  logic [2:0]       ready_v = '0;
  logic [2:0][4:0]  px, py, mx, my;
  logic [2:0][2:0]  pt;
  logic [2:0]       pv, busy, done, mrw;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] t;
  } tile_t;

  tile_t exp_q[$];

  // Instance 1 holds a sparse map; the others hold (x+y) mod 8.
  function automatic logic [2:0] map_code(input int g, input logic [4:0] x, input logic [4:0] y);
    int s;
    if (g == 1) begin
      if (x == 5'd3 && y == 5'd0)   return 3'd2;
      if (x == 5'd19 && y == 5'd19) return 3'd5;
      return 3'd0;
    end
    s = (int'(x) + int'(y)) % 8;
    return 3'(s);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : u
      localparam int LAT = (g == 2) ? 3 : 2;
      localparam int SKP = (g == 1) ? 1 : 0;
      logic [2:0] q1, q2;
      map_scan_reader_if bus ();
      map_scan_reader #(
        .MAP_WIDTH   (20),
        .MAP_HEIGHT  (20),
        .READ_LATENCY(LAT),
        .SKIP_EMPTY  (SKP)
      ) dut (
        .clock_50(clk),
        .reset_n (rst_n),
        .bus     (bus)
      );
      // Model RAM: map_x/map_y are already registered, so LAT-1 more stages.
      always @(posedge clk) begin
        q1 <= map_code(g, bus.map_x, bus.map_y);
        q2 <= q1;
      end
      assign bus.map_data_in = (LAT == 3) ? q2 : q1;
      assign bus.start       = start_v[g];
      assign bus.plot_ready  = ready_v[g];
      assign px[g]   = bus.plot_x;
      assign py[g]   = bus.plot_y;
      assign pt[g]   = bus.plot_type;
      assign mx[g]   = bus.map_x;
      assign my[g]   = bus.map_y;
      assign pv[g]   = bus.plot_valid;
      assign busy[g] = bus.busy;
      assign done[g] = bus.done;
      assign mrw[g]  = bus.map_readwrite;
    end
  endgenerate

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_of(input int g);
    return int'({busy[g], done[g], pv[g], mrw[g], mx[g], my[g], px[g], py[g], pt[g]});
  endfunction

  // One full scan on instance g. rmode 0: ready held high, 1: random ready.
  // poke pulses start mid-scan and in the DONE cycle; neither may restart.
  task automatic run_scan(input int g, input int rmode, input int poke,
                          input int exp_hs, input int exp_cyc, input string tag);
    int hs = 0, c = 0, dcyc = -1;
    int order_err = 0, stab_err = 0, busy_err = 0, rw_err = 0, extra = 0;
    logic r;
    logic stall_p = 1'b0;
    logic [4:0] px_p = '0, py_p = '0, mx_p = '0, my_p = '0;
    logic [2:0] pt_p = '0;
    tile_t e;
    logic [2:0] code;

    exp_q.delete();
    for (int yy = 0; yy < 20; yy++) begin
      for (int xx = 0; xx < 20; xx++) begin
        code = map_code(g, 5'(xx), 5'(yy));
        if (!(g == 1 && code == 3'd0)) exp_q.push_back(tile_t'{5'(xx), 5'(yy), code});
      end
    end

    @(negedge clk);
    check({tag, "_idle_busy"}, int'(busy[g]), 0);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;

    while (c < 6000) begin
      if (mrw[g]) rw_err++;
      if (stall_p && (!pv[g] || px[g] !== px_p || py[g] !== py_p || pt[g] !== pt_p ||
                      mx[g] !== mx_p || my[g] !== my_p)) stab_err++;
      if (done[g]) begin
        dcyc = c;
        break;
      end
      if (!busy[g]) busy_err++;
      r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start_v[g] = (poke != 0 && c == 50);
      ready_v[g] = r;
      if (pv[g] && r) begin
        if (exp_q.size() == 0) begin
          order_err++;
        end else begin
          e = exp_q.pop_front();
          if (e.x !== px[g] || e.y !== py[g] || e.t !== pt[g]) order_err++;
        end
        hs++;
      end
      stall_p = pv[g] && !r;
      px_p = px[g]; py_p = py[g]; pt_p = pt[g]; mx_p = mx[g]; my_p = my[g];
      @(negedge clk);
      c++;
    end

    if (exp_cyc >= 0) check({tag, "_done_cycle"}, dcyc, exp_cyc);
    else              check({tag, "_done_reached"}, int'(dcyc >= 0), 1);
    check({tag, "_busy_in_done"}, int'(busy[g]), 0);

    // start in the DONE cycle must be ignored
    start_v[g] = (poke != 0);
    @(negedge clk);
    start_v[g] = 1'b0;
    check({tag, "_done_pulse_width"}, int'(done[g]), 0);
    repeat (5) begin
      @(negedge clk);
      if (done[g] || busy[g]) extra++;
    end
    check({tag, "_no_restart"}, extra, 0);
    check({tag, "_handshakes"}, hs, exp_hs);
    check({tag, "_tiles_left"}, exp_q.size(), 0);
    check({tag, "_order_errs"}, order_err, 0);
    check({tag, "_stall_errs"}, stab_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_readwrite"}, rw_err, 0);
  endtask

  // Abandon a scan with reset while tile (7,4) is being presented.
  task automatic reset_mid_scan();
    int found = 0, extra = 0;
    @(negedge clk);
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (pv[0] && px[0] == 5'd7 && py[0] == 5'd4) begin
        found = 1;
        ready_v[0] = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached_7_4", found, 1);
    #1 rst_n = 1'b0;
    #1 check("rst_async_outputs", outs_of(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_v[0] = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done[0] || busy[0]) extra++;
    end
    check("rst_no_done_after", extra, 0);
  endtask

  typedef struct {
    int    g;
    int    rmode;
    int    poke;
    int    exp_hs;
    int    exp_cyc;
    string tag;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // 20x20 tiles: 3 cycles each at latency 2, 4 at latency 3;
    // skip map: 398 skipped tiles at 2 cycles plus 2 plotted at 3.
    tbl[0] = '{0, 0, 0, 400, 1200, "full"};
    tbl[1] = '{0, 1, 0, 400, -1,   "random_ready"};
    tbl[2] = '{1, 0, 0, 2,   802,  "skip_empty"};
    tbl[3] = '{2, 0, 0, 400, 1600, "latency3"};
    tbl[4] = '{0, 0, 1, 400, 1200, "start_poke"};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) check($sformatf("reset_outputs_%0d", g), outs_of(g), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_scan(tbl[i].g, tbl[i].rmode, tbl[i].poke, tbl[i].exp_hs, tbl[i].exp_cyc, tbl[i].tag);
    end

    reset_mid_scan();
    run_scan(0, 0, 0, 400, 1200, "rescan_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
